// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback has priority over buffered mul/div results, with starvation-forced drains and WAW kill.
// Optional macro WBARB_BYPASS_EN lets a multi-cycle result skip an empty FIFO when the port is idle.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dst,
  input  logic [63:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_dst,
  input  logic [63:0] md_data,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  input  logic [4:0]  q_src1,
  input  logic [4:0]  q_src2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t           state;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] kill_mask;
  logic [4:0]       ent_dst  [DEPTH];
  logic [63:0]      ent_data [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  logic             alive;

  logic             grant_wb;
  logic             grant_head;
  logic             bypass;
  logic             push;
  logic             kill_en;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [63:0]      wr_data;

  // alive keeps md_ready low throughout reset while still decoding from registers only
  assign md_ready = alive && (count < CW'(DEPTH));
  assign busy     = |ent_valid;
  assign kill_en  = grant_wb && (wb_dst != 5'd0);
  assign push     = md_valid && md_ready && (md_dst != 5'd0) && !bypass;

`ifdef WBARB_BYPASS_EN
  assign bypass = (state == NORMAL) && (count == '0) && !wb_valid && alive && md_valid && (md_dst != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    wb_stall   = 1'b0;
    if (state == FORCE) begin
      grant_head = (count != '0);
      wb_stall   = wb_valid;
    end else if (wb_valid) begin
      grant_wb = 1'b1;
    end else begin
      grant_head = (count != '0);
    end
  end

  // Queries see pre-kill, pre-push state; the kill mask spares a same-cycle push by construction
  always_comb begin
    q_hit1    = 1'b0;
    q_hit2    = 1'b0;
    kill_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_dst[i] == q_src1)) q_hit1 = 1'b1;
      if (ent_valid[i] && (ent_dst[i] == q_src2)) q_hit2 = 1'b1;
      if (ent_valid[i] && kill_en && (ent_dst[i] == wb_dst)) kill_mask[i] = 1'b1;
    end
    if (q_src1 == 5'd0) q_hit1 = 1'b0;
    if (q_src2 == 5'd0) q_hit2 = 1'b0;
  end

  always_comb begin
    valid_next = ent_valid & ~kill_mask;
    if (grant_head) valid_next[rptr] = 1'b0;
    if (push)       valid_next[wptr] = 1'b1;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wb_dst;
    wr_data = wb_data;
    if (grant_wb) begin
      wr_en = (wb_dst != 5'd0);
    end else if (grant_head) begin
      wr_en   = ent_valid[rptr];
      wr_addr = ent_dst[rptr];
      wr_data = ent_data[rptr];
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_addr = md_dst;
      wr_data = md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_dst[wptr]  <= md_dst;
      ent_data[wptr] <= md_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      alive     <= 1'b0;
    end else begin
      alive     <= 1'b1;
      ent_valid <= valid_next;
      count     <= count + CW'(push) - CW'(grant_head);
      if (push)       wptr <= wptr + 1'b1;
      if (grant_head) rptr <= rptr + 1'b1;
    end
  end

  // FORCE coincides with the counter reaching the limit and lasts until the head pops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else if (grant_head || (count == '0)) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) state <= FORCE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 64'd0;
    end else begin
      rf_wen <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
// Honours WBARB_BYPASS_EN in the model when the design is built with it.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic        v;
    logic [4:0]  dst;
    logic [63:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_dst;
  logic [63:0] md_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  q_src1;
  logic [4:0]  q_src2;
  logic        q_hit1;
  logic        q_hit2;
  logic        busy;

  int pass_count  = 0;
  int check_count = 0;

  entry_t      fifo_q[$];
  int          starve;
  bit          alive;
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_dst(md_dst), .md_data(md_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_src1(q_src1), .q_src2(q_src2), .q_hit1(q_hit1), .q_hit2(q_hit2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
  endtask

  function automatic logic modelHit(input logic [4:0] src);
    logic hit = 1'b0;
    foreach (fifo_q[i]) if (fifo_q[i].v && fifo_q[i].dst == src) hit = 1'b1;
    return (src != 5'd0) && hit;
  endfunction

  function automatic logic modelBusy();
    logic any = 1'b0;
    foreach (fifo_q[i]) if (fifo_q[i].v) any = 1'b1;
    return any;
  endfunction

  function automatic logic modelReady();
    return alive && (fifo_q.size() < DEPTH);
  endfunction

  // One port cycle of the reference: decide the grant, then kill, pop, push and age the head
  task automatic modelStep();
    int     sz    = fifo_q.size();
    bit     frc   = (starve == STARVE_LIMIT);
    bit     g_wb  = !frc && wb_valid;
    bit     g_hd  = (frc || !wb_valid) && (sz > 0);
    bit     byp   = 1'b0;
    bit     psh;
    entry_t e;
`ifdef WBARB_BYPASS_EN
    byp = !frc && (sz == 0) && !wb_valid && md_valid && (md_dst != 5'd0) && alive;
`endif
    psh = md_valid && modelReady() && (md_dst != 5'd0) && !byp;
    exp_wen = 1'b0;
    if (g_wb) begin
      exp_wen   = (wb_dst != 5'd0);
      exp_waddr = wb_dst;
      exp_wdata = wb_data;
    end else if (g_hd) begin
      e         = fifo_q[0];
      exp_wen   = e.v;
      exp_waddr = e.dst;
      exp_wdata = e.data;
    end else if (byp) begin
      exp_wen   = 1'b1;
      exp_waddr = md_dst;
      exp_wdata = md_data;
    end
    if (g_wb && wb_dst != 5'd0)
      foreach (fifo_q[i]) if (fifo_q[i].dst == wb_dst) fifo_q[i].v = 1'b0;
    if (g_hd) void'(fifo_q.pop_front());
    if (psh) begin
      e.v = 1'b1; e.dst = md_dst; e.data = md_data;
      fifo_q.push_back(e);
    end
    if (g_hd || sz == 0) starve = 0;
    else if (starve < STARVE_LIMIT) starve++;
    alive = 1'b1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wd, input logic [63:0] wdat,
                               input logic mv, input logic [4:0] mdd, input logic [63:0] mdat,
                               input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    checkOutput("rf_wen", rf_wen, exp_wen);
    if (exp_wen) begin
      checkOutput("rf_waddr", rf_waddr, exp_waddr);
      checkOutput("rf_wdata", rf_wdata, exp_wdata);
    end
    wb_valid = wv; wb_dst = wd; wb_data = wdat;
    md_valid = mv; md_dst = mdd; md_data = mdat;
    q_src1 = s1; q_src2 = s2;
    #1;
    checkOutput("md_ready", md_ready, modelReady());
    checkOutput("wb_stall", wb_stall, (starve == STARVE_LIMIT) && wv);
    checkOutput("q_hit1", q_hit1, modelHit(s1));
    checkOutput("q_hit2", q_hit2, modelHit(s2));
    checkOutput("busy", busy, modelBusy());
    modelStep();
  endtask

  // Asserts reset between edges so the asynchronous clear is visible before any clock
  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    wb_valid = 1'b0; wb_dst = 5'd0; wb_data = 64'd0;
    md_valid = 1'b0; md_dst = 5'd0; md_data = 64'd0;
    q_src1 = 5'd0; q_src2 = 5'd0;
    #1;
    checkOutput("rst_rf_wen", rf_wen, 1'b0);
    checkOutput("rst_rf_waddr", rf_waddr, 5'd0);
    checkOutput("rst_rf_wdata", rf_wdata, 64'd0);
    checkOutput("rst_md_ready", md_ready, 1'b0);
    checkOutput("rst_wb_stall", wb_stall, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_q_hit1", q_hit1, 1'b0);
    checkOutput("rst_q_hit2", q_hit2, 1'b0);
    fifo_q.delete();
    starve  = 0;
    alive   = 1'b0;
    exp_wen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_md_ready", md_ready, 1'b0);
    modelStep();
  endtask

  initial begin
    reset = 1'b0;
    wb_valid = 1'b0; wb_dst = 5'd0; wb_data = 64'd0;
    md_valid = 1'b0; md_dst = 5'd0; md_data = 64'd0;
    q_src1 = 5'd0; q_src2 = 5'd0;
    fifo_q.delete();
    starve = 0; alive = 1'b0; exp_wen = 1'b0;
    exp_waddr = 5'd0; exp_wdata = 64'd0;
    applyReset();

    // Writeback only
    repeat (3) applyStimulus(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

    // Fill under writeback pressure and let starvation force both drains
    applyStimulus(1'b1, 5'd1, 64'h100, 1'b1, 5'd3, 64'h333, 5'd3, 5'd4);
    applyStimulus(1'b1, 5'd1, 64'h101, 1'b1, 5'd4, 64'h444, 5'd3, 5'd4);
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b1, 5'd2, 64'(i), 1'b1, 5'd6, 64'h666, 5'd3, 5'd4);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    repeat (4) applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd6, 5'd0);

    // Fill again, then reset mid-drain
    applyStimulus(1'b1, 5'd1, 64'h200, 1'b1, 5'd3, 64'h3, 5'd3, 5'd0);
    applyStimulus(1'b1, 5'd1, 64'h201, 1'b1, 5'd4, 64'h4, 5'd4, 5'd0);
    applyStimulus(1'b1, 5'd1, 64'h202, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    applyReset();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);

    // WAW kill: younger writeback to r7 overwrites the buffered r7 result
    applyStimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd7, 64'h11, 5'd7, 5'd0);
    applyStimulus(1'b1, 5'd7, 64'h22, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);

    // x0 on both sources
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd0, 64'h77, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 5'd9, 5'd0);
    repeat (3) applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);

    // Random traffic with small register range to provoke collisions
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) applyReset();
      applyStimulus($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port, shared between the in-order writeback stage and the out-of-band multi-cycle unit (mul/div) completion path. Multi-cycle results enter a small FIFO and drain into idle write-port cycles. Writeback has priority, subject to a starvation limit that stalls writeback so the FIFO can drain. The block also kills buffered results overwritten by younger writeback instructions (WAW) and exposes a pending-write query for hazard detection in decode.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, default 4: consecutive cycles the FIFO head may wait before a forced drain; ≥1.

Ports:
- `clk`: in, 1. Clock.
- `reset`: in, 1. Asynchronous, active-low reset.
- `wb_valid`: in, 1. Writeback stage has a register write this cycle.
- `wb_dst`: in, 5. Writeback destination register.
- `wb_data`: in, 64. Writeback result.
- `wb_stall`: out, 1. Writeback write not taken this cycle; the pipeline holds writeback.
- `md_valid`: in, 1. Multi-cycle unit offers a result.
- `md_ready`: out, 1. FIFO can accept a result.
- `md_dst`: in, 5. Multi-cycle destination register.
- `md_data`: in, 64. Multi-cycle result.
- `rf_wen`: out, 1. Register-file write enable (registered).
- `rf_waddr`: out, 5. Register-file write address (registered).
- `rf_wdata`: out, 64. Register-file write data (registered).
- `q_src1`: in, 5. Decode source register 1.
- `q_src2`: in, 5. Decode source register 2.
- `q_hit1`: out, 1. A valid FIFO entry targets `q_src1`.
- `q_hit2`: out, 1. A valid FIFO entry targets `q_src2`.
- `busy`: out, 1. FIFO holds at least one valid entry.

## Operation
- **FIFO.** Holds DEPTH entries of {valid, dst, data}, with read and write pointers that wrap modulo DEPTH.
  - An occupancy count of width clog2(DEPTH)+1 tracks allocated slots; killed entries still occupy their slot until popped.
  - `md_ready` = (count < DEPTH), decoded from registered state only.
  - A push happens on `md_valid & md_ready`.
  - A push with `md_dst`==0 allocates no slot and is discarded.
- **Arbiter states.**
  - NORMAL: the grant goes to writeback if `wb_valid`; otherwise to the FIFO head if count>0.
  - FORCE: the grant goes to the FIFO head; `wb_stall` = `wb_valid`.
- **Starvation counter.**
  - `starve_cnt` increments each cycle count>0 and the head is not popped; it saturates at STARVE_LIMIT.
  - It clears whenever the head pops or count==0.
  - NORMAL→FORCE when `starve_cnt`==STARVE_LIMIT.
  - FORCE→NORMAL after exactly one head pop.
- **Head grant.** Pops the head.
  - If the head is valid, it drives a write.
  - If the head is killed, it pops with no write that cycle; the port cycle is wasted, which bounds logic depth.
- **WAW kill.** A granted writeback write with dst D≠0 clears the valid bit of every FIFO entry with dst==D, in the same cycle. A same-cycle push with dst D is not killed.
- **x0.** A grant to dst 0 never raises `rf_wen`.
- **Query.** `q_hitN` = (`q_srcN`≠0) & OR over valid entries of (dst==`q_srcN`). It is combinational and reflects state before the current cycle's kill and push.
- **Busy.** `busy` = OR of the entry valid bits.
- **Simultaneous push and pop.**
  - A push and a pop in the same cycle leave count unchanged.
  - A push into an empty FIFO cannot pop the same cycle, except under the macro below.

## Timing
- **Write latency.**
  - A grant in cycle t yields `rf_wen`/`rf_waddr`/`rf_wdata` in cycle t+1. Each write is held for one cycle.
  - A writeback write reaches the register file one cycle after `wb_valid`.
  - A multi-cycle result accepted at t writes no earlier than t+2.
- **Stall.** `wb_stall` is combinational from state and `wb_valid`. It is asserted only in FORCE, for one cycle per forced pop.
- **Reset.**
  - While `reset`=0: all pointers, count, valid bits, and `starve_cnt` are 0; state is NORMAL.
  - While `reset`=0: `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `md_ready`=0, `wb_stall`=0, `busy`=0, `q_hit1`=0, `q_hit2`=0.
  - A mid-operation reset discards all buffered results.
- **Full.** `md_ready`=0; `md_valid` is ignored and the multi-cycle unit must hold its result.
- **Empty.** FORCE is unreachable.

## Configuration
- `WBARB_BYPASS_EN` defined:
  - A bypass occurs in NORMAL when count==0, `wb_valid`=0, and `md_valid`=1 with `md_dst`≠0.
  - The result is granted directly, without allocating a FIFO slot.
  - `rf_wen` is raised at t+1.
- `WBARB_BYPASS_EN` undefined: every multi-cycle result passes through the FIFO, with a minimum latency of 2.

## Test plan
- **Writeback only.** `wb_valid`=1, dst=5, data=0xAA, for 3 cycles → `rf_wen`=1, `rf_waddr`=5 at cycles 1–3; `wb_stall`=0 throughout.
- **Fill and backpressure.** With `wb_valid` held 1, push 2 multi-cycle results (dst 3, 4) → `md_ready`=0 after the second push. FORCE is entered after 4 waiting cycles: `wb_stall`=1 and `rf_waddr`=3 on the next cycle, then NORMAL.
- **WAW kill.** Push dst 7 data 0x11 while writeback busy. Then writeback dst 7 data 0x22 → `q_hit1`(`q_src1`=7) falls to 0 the cycle after. Head pops with `rf_wen`=0 and the register file never sees 0x11.
- **x0.** `md_dst`=0 accepted → count unchanged, no write. `wb_dst`=0 → `rf_wen`=0.
- **Async reset.** Drop `reset` mid-drain with count=2 → all outputs 0 immediately; after release, `busy`=0 and `md_ready`=1.
- **Bypass.** With `WBARB_BYPASS_EN` defined, FIFO empty, and `md_valid` with dst 9 → `rf_wen`=1, `rf_waddr`=9 at t+1, count stays 0. Without the macro: t+2, count=1 at t+1.
